// File: rtl/mips_cpu_bus_ctrl_pkg.sv
// Shared types for the MIPS bus controller: access sizes, FSM states, grant owner.
// Pure declarations; no logic, no latency.
package mips_cpu_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } bus_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

endpackage

// File: rtl/mips_cpu_bus_ctrl_if.sv
// Core-side request/response and Avalon-MM master signals of the bus controller.
// master = the controller itself; slave = core plus memory environment.
interface mips_cpu_bus_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic              d_signed;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    logic              busy;

    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic                waitrequest;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata,
        input  waitrequest, readdata,
        output if_done, if_rdata, d_done, d_rdata, d_err, busy,
        output address, read, write, writedata, byteenable
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata,
        output waitrequest, readdata,
        input  if_done, if_rdata, d_done, d_rdata, d_err, busy,
        input  address, read, write, writedata, byteenable
    );
endinterface

// File: rtl/mips_cpu_bus_ctrl_lane.sv
// Byte-lane steering: byteenable, replicated writedata, misalign flag, extended load data.
// Purely combinational, zero latency, no backpressure.
import mips_cpu_bus_ctrl_pkg::*;

module mips_cpu_bus_lane (
    input  access_size_t i_size,
    input  logic         i_signed,
    input  logic [1:0]   i_lo,
    input  logic [31:0]  i_wdata,
    input  logic [31:0]  i_rdata,
    output logic [3:0]   o_be,
    output logic [31:0]  o_wdata,
    output logic         o_misalign,
    output logic [31:0]  o_rdata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_lo, 3'b000} +: 8];
    assign w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        o_rdata    = i_rdata;
        case (i_size)
            BYTE: begin
                o_be    = 4'b0001 << i_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            HALF: begin
                o_be       = i_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_lo[0];
                o_rdata    = {{16{i_signed & w_half[15]}}, w_half};
            end
            default: begin
                o_misalign = (i_lo != 2'b00);
            end
        endcase
    end
endmodule

// File: rtl/mips_cpu_bus_ctrl.sv
// Round-robin fetch/data arbiter driving one Avalon-MM master; done at N+2 plus waitrequest cycles.
// Holds the bus stable under waitrequest; optional abort via MIPS_BUS_TIMEOUT_EN.
import mips_cpu_bus_ctrl_pkg::*;

module mips_cpu_bus_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    mips_cpu_bus_ctrl_if.master bus
);
    bus_state_t        r_state, w_state_nxt;
    grant_t            r_grant, r_last_grant, w_grant;
    logic              w_any, w_sel_we, w_sel_signed, w_timeout, w_if_done, w_d_done;
    access_size_t      w_sel_size, w_lane_size;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic [ADDR_W-3:0] r_addr_hi;
    logic [1:0]        r_lo;
    access_size_t      r_size;
    logic              r_signed, r_read, r_write, r_err;
    logic [DATA_W-1:0] r_wdata, r_resp;
    logic [3:0]        r_be;

    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata, w_ext;
    logic              w_misalign;

    // Fetch wins when alone, or when data was served last.
    assign w_any        = bus.if_req | bus.d_req;
    assign w_grant      = (bus.if_req && (!bus.d_req || r_last_grant == DATA)) ? FETCH : DATA;
    assign w_sel_we     = (w_grant == DATA) & bus.d_we;
    assign w_sel_size   = (w_grant == FETCH) ? WORD : access_size_t'(bus.d_size);
    assign w_sel_signed = (w_grant == DATA) & bus.d_signed;
    assign w_sel_addr   = (w_grant == FETCH) ? bus.if_addr : bus.d_addr;
    assign w_sel_wdata  = (w_grant == FETCH) ? '0 : bus.d_wdata;

    // One lane unit serves both phases: request steering in IDLE, load extension in BUS.
    assign w_lane_size = (r_state == IDLE) ? w_sel_size : r_size;

    mips_cpu_bus_lane u_lane (
        .i_size     (w_lane_size),
        .i_signed   ((r_state == IDLE) ? w_sel_signed : r_signed),
        .i_lo       ((r_state == IDLE) ? w_sel_addr[1:0] : r_lo),
        .i_wdata    (w_sel_wdata),
        .i_rdata    (bus.readdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign),
        .o_rdata    (w_ext)
    );

`ifdef MIPS_BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (reset || r_state != BUS) begin
            r_to_cnt <= '0;
        end else if (bus.waitrequest) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == BUS) && bus.waitrequest &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = w_misalign ? RESP : BUS;
            BUS:     if (!bus.waitrequest || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= FETCH;
            r_last_grant <= DATA;
            r_addr_hi    <= '0;
            r_lo         <= '0;
            r_size       <= BYTE;
            r_signed     <= 1'b0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_wdata      <= '0;
            r_resp       <= '0;
            r_be         <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: if (w_any) begin
                    r_grant      <= w_grant;
                    r_last_grant <= w_grant;
                    r_addr_hi    <= w_sel_addr[ADDR_W-1:2];
                    r_lo         <= w_sel_addr[1:0];
                    r_size       <= w_sel_size;
                    r_signed     <= w_sel_signed;
                    r_be         <= w_be;
                    r_wdata      <= w_wdata;
                    r_resp       <= '0;
                    r_err        <= w_misalign && (w_grant == DATA);
                    r_read       <= !w_misalign && !w_sel_we;
                    r_write      <= !w_misalign && w_sel_we;
                end
                BUS: if (!bus.waitrequest) begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_resp  <= r_write ? '0 : w_ext;
                end else if (w_timeout) begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_resp  <= '0;
                    r_err   <= (r_grant == DATA);
                end
                default: ;
            endcase
        end
    end

    assign w_if_done      = (r_state == RESP) && (r_grant == FETCH);
    assign w_d_done       = (r_state == RESP) && (r_grant == DATA);
    assign bus.if_done    = w_if_done;
    assign bus.d_done     = w_d_done;
    assign bus.if_rdata   = w_if_done ? r_resp : '0;
    assign bus.d_rdata    = w_d_done ? r_resp : '0;
    assign bus.d_err      = w_d_done & r_err;
    assign bus.busy       = (r_state != IDLE);
    assign bus.address    = {r_addr_hi, 2'b00};
    assign bus.read       = r_read;
    assign bus.write      = r_write;
    assign bus.writedata  = r_wdata;
    assign bus.byteenable = r_be;
endmodule

// File: tb/tb_mips_cpu_bus_ctrl.sv
// Bench for mips_cpu_bus_ctrl: directed table, arbitration/reset sequences, randomized
// transactions against a transaction-level reference model.
import mips_cpu_bus_ctrl_pkg::*;

module tb_mips_cpu_bus_ctrl;
    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    grant_t m_last;

    mips_cpu_bus_ctrl_if bif ();

    mips_cpu_bus_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        fetch;
        bit        we;
        bit [1:0]  size;
        bit        sgn;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        int        waits;
        bit        mis;
        bit [31:0] e_addr;
        bit [3:0]  e_be;
        bit [31:0] e_wdata;
        bit [31:0] e_rdata;
        bit        e_err;
    } vec_t;

    vec_t tbl [12];

    // A requester must hold its request until its done pulse.
    logic a_d_q, a_i_q, a_d_seen, a_i_seen;
    always @(posedge clk) begin
        if (reset) begin
            a_d_q <= 1'b0; a_i_q <= 1'b0; a_d_seen <= 1'b0; a_i_seen <= 1'b0;
        end else begin
            if (a_d_q && !bif.d_req) assert (a_d_seen) else $error("d_req dropped before d_done");
            if (a_i_q && !bif.if_req) assert (a_i_seen) else $error("if_req dropped before if_done");
            a_d_q    <= bif.d_req;
            a_i_q    <= bif.if_req;
            a_d_seen <= bif.d_req ? (a_d_seen | bif.d_done) : 1'b0;
            a_i_seen <= bif.if_req ? (a_i_seen | bif.if_done) : 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: derive the expected bus image and result from size/offset arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int nb, off;
        logic [63:0] val, span;
        nb  = v.fetch ? 4 : (1 << v.size);
        off = int'(v.addr % 4);
        r.mis    = (off % nb) != 0;
        r.e_addr = v.addr - 32'(off);
        r.e_be   = 4'(((1 << nb) - 1) << off);
        if (v.fetch)      r.e_wdata = 32'h0;
        else if (nb == 1) r.e_wdata = (v.wdata & 32'hFF) * 32'h01010101;
        else if (nb == 2) r.e_wdata = (v.wdata & 32'hFFFF) * 32'h00010001;
        else              r.e_wdata = v.wdata;
        span = 64'd1 << (8 * nb);
        val  = ({32'd0, v.rdata} >> (8 * off)) & (span - 64'd1);
        if (v.sgn && nb < 4 && val[8*nb-1]) val = val - span;
        r.e_rdata = (r.mis || (v.we && !v.fetch)) ? 32'h0 : val[31:0];
        r.e_err   = r.mis && !v.fetch;
        return r;
    endfunction

    task automatic run_one(input string nm, input vec_t v);
        int rem = v.waits, bus_cyc = 0, lat = 0;
        bit got = 0, stable = 1, wrong = 0, lingering;
        logic [31:0] s_addr = 0, s_wd = 0, r_dat = 0;
        logic [3:0]  s_be = 0;
        logic        s_rd = 0, s_wr = 0, r_err = 0;
        if (v.fetch) begin
            bif.if_req = 1'b1; bif.if_addr = v.addr;
        end else begin
            bif.d_req = 1'b1; bif.d_we = v.we; bif.d_size = v.size; bif.d_signed = v.sgn;
            bif.d_addr = v.addr; bif.d_wdata = v.wdata;
        end
        @(posedge clk);
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (bif.read || bif.write) begin
                if (bus_cyc == 0) begin
                    s_addr = bif.address; s_be = bif.byteenable; s_wd = bif.writedata;
                    s_rd = bif.read; s_wr = bif.write;
                end else if (bif.address !== s_addr || bif.byteenable !== s_be ||
                             bif.writedata !== s_wd || bif.read !== s_rd || bif.write !== s_wr) begin
                    stable = 0;
                end
                bus_cyc++;
                if (rem > 0) begin
                    bif.waitrequest = 1'b1; rem--;
                end else begin
                    bif.waitrequest = 1'b0; bif.readdata = v.rdata;
                end
            end
            if (v.fetch ? (bif.d_done || bif.d_err) : bif.if_done) wrong = 1;
            if (v.fetch ? bif.if_done : bif.d_done) begin
                got = 1; lat = c;
                r_dat = v.fetch ? bif.if_rdata : bif.d_rdata;
                r_err = bif.d_err;
                break;
            end
        end
        @(posedge clk); #1;
        bif.if_req = 1'b0; bif.d_req = 1'b0; bif.waitrequest = 1'b0; bif.readdata = $urandom;
        @(negedge clk);
        lingering = bif.if_done | bif.d_done;
        m_last = v.fetch ? FETCH : DATA;

        chk({nm, "_done"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, lat, v.mis ? 1 : 2 + v.waits);
        chk({nm, "_buscycles"}, bus_cyc, v.mis ? 0 : v.waits + 1);
        if (!v.mis) begin
            chk({nm, "_address"}, s_addr, v.e_addr);
            chk({nm, "_byteenable"}, 32'(s_be), 32'(v.e_be));
            chk({nm, "_writedata"}, s_wd, v.e_wdata);
            chk({nm, "_rw"}, {30'd0, s_rd, s_wr}, {30'd0, !v.we, v.we});
            chk({nm, "_stable"}, 32'(stable), 32'd1);
        end
        chk({nm, "_rdata"}, r_dat, v.e_rdata);
        chk({nm, "_err"}, 32'(r_err), 32'(v.e_err));
        chk({nm, "_wrongdone"}, 32'(wrong), 32'd0);
        chk({nm, "_onepulse"}, 32'(lingering), 32'd0);
    endtask

    task automatic run_pair(input string nm, input logic [31:0] fa, input logic [31:0] da,
                            input logic [31:0] rd);
        grant_t exp_first  = (m_last == DATA) ? FETCH : DATA;
        grant_t exp_second = (exp_first == FETCH) ? DATA : FETCH;
        grant_t who [2] = '{exp_second, exp_first};
        int     when [2] = '{0, 0};
        logic [31:0] dat [2] = '{32'h0, 32'h0};
        int  n_done = 0;
        bit  drop_f = 0, drop_d = 0, clash = 0;
        bif.if_req = 1'b1; bif.if_addr = fa;
        bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_size = 2'b10; bif.d_signed = 1'b0; bif.d_addr = da;
        bif.waitrequest = 1'b0; bif.readdata = rd;
        for (int c = 1; c <= 30 && n_done < 2; c++) begin
            @(posedge clk); #1;
            if (drop_f) bif.if_req = 1'b0;
            if (drop_d) bif.d_req = 1'b0;
            @(negedge clk);
            if (bif.if_done && bif.d_done) begin
                clash = 1;
            end else if (bif.if_done) begin
                who[n_done] = FETCH; when[n_done] = c; dat[n_done] = bif.if_rdata; n_done++; drop_f = 1;
            end else if (bif.d_done) begin
                who[n_done] = DATA; when[n_done] = c; dat[n_done] = bif.d_rdata; n_done++; drop_d = 1;
            end
        end
        @(posedge clk); #1;
        bif.if_req = 1'b0; bif.d_req = 1'b0;
        m_last = exp_second;
        chk({nm, "_count"}, n_done, 2);
        chk({nm, "_clash"}, 32'(clash), 32'd0);
        chk({nm, "_first"}, 32'(who[0]), 32'(exp_first));
        chk({nm, "_second"}, 32'(who[1]), 32'(exp_second));
        chk({nm, "_t_first"}, when[0], 2);
        chk({nm, "_t_second"}, when[1], 5);
        chk({nm, "_d_first"}, dat[0], rd);
        chk({nm, "_d_second"}, dat[1], rd);
    endtask

    initial begin
        vec_t v;
        int   dones, lat, bus_cyc;
        logic [31:0] to_dat;
        logic to_err;

        tbl[0]  = '{1, 0, 2'd2, 0, 32'hBFC00004, 32'h0, 32'h8C020000, 0, 0, 32'hBFC00004, 4'hF, 32'h0, 32'h8C020000, 0};
        tbl[1]  = '{0, 1, 2'd0, 0, 32'h00001003, 32'h000000AB, 32'h0, 3, 0, 32'h00001000, 4'b1000, 32'hABABABAB, 32'h0, 0};
        tbl[2]  = '{0, 0, 2'd1, 1, 32'h00002002, 32'h0, 32'h8001FFFF, 0, 0, 32'h00002000, 4'b1100, 32'h0, 32'hFFFF8001, 0};
        tbl[3]  = '{0, 0, 2'd1, 0, 32'h00002002, 32'h0, 32'h8001FFFF, 0, 0, 32'h00002000, 4'b1100, 32'h0, 32'h00008001, 0};
        tbl[4]  = '{0, 0, 2'd2, 0, 32'h00003001, 32'h0, 32'h12345678, 0, 1, 32'h00003000, 4'hF, 32'h0, 32'h0, 1};
        tbl[5]  = '{1, 0, 2'd2, 0, 32'h00400002, 32'h0, 32'hFFFFFFFF, 0, 1, 32'h00400000, 4'hF, 32'h0, 32'h0, 0};
        tbl[6]  = '{0, 0, 2'd0, 1, 32'h00001001, 32'h0, 32'h00008000, 2, 0, 32'h00001000, 4'b0010, 32'h0, 32'hFFFFFF80, 0};
        tbl[7]  = '{0, 1, 2'd1, 0, 32'h00002000, 32'h1234ABCD, 32'h0, 0, 0, 32'h00002000, 4'b0011, 32'hABCDABCD, 32'h0, 0};
        tbl[8]  = '{0, 1, 2'd2, 0, 32'h00004000, 32'hDEADBEEF, 32'h0, 1, 0, 32'h00004000, 4'hF, 32'hDEADBEEF, 32'h0, 0};
        tbl[9]  = '{0, 0, 2'd1, 1, 32'h00002001, 32'h0, 32'hFFFFFFFF, 0, 1, 32'h00002000, 4'b0011, 32'h0, 32'h0, 1};
        tbl[10] = '{0, 0, 2'd0, 0, 32'h00005003, 32'h0, 32'h9A000000, 0, 0, 32'h00005000, 4'b1000, 32'h0, 32'h0000009A, 0};
        tbl[11] = '{0, 1, 2'd0, 0, 32'h00006000, 32'h12345678, 32'h0, 0, 0, 32'h00006000, 4'b0001, 32'h78787878, 32'h0, 0};

        reset = 1'b1;
        bif.if_req = 0; bif.if_addr = 0; bif.d_req = 0; bif.d_we = 0; bif.d_size = 0;
        bif.d_signed = 0; bif.d_addr = 0; bif.d_wdata = 0; bif.waitrequest = 0; bif.readdata = 0;
        m_last = DATA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_rw", {30'd0, bif.read, bif.write}, 32'd0);
        chk("rst_address", bif.address, 32'd0);
        chk("rst_be_wd", {bif.writedata[27:0], bif.byteenable}, 32'd0);
        chk("rst_done", {29'd0, bif.if_done, bif.d_done, bif.d_err}, 32'd0);
        chk("rst_rdata", bif.if_rdata | bif.d_rdata, 32'd0);
        reset = 1'b0;

        run_pair("pair0", 32'hBFC00000, 32'h00008000, 32'h11223344);
        for (int i = 0; i < 12; i++) run_one($sformatf("vec%0d", i), tbl[i]);
        run_one("fetch_pre", model('{1, 0, 2'd2, 0, 32'h00000040, 32'h0, 32'h0BADF00D, 0, 0, 0, 0, 0, 0, 0}));
        run_pair("pair1", 32'h00000100, 32'h00000200, 32'hCAFEF00D);
        run_pair("pair2", 32'h00000104, 32'h00000204, 32'h5A5AA5A5);

        for (int i = 0; i < 40; i++) begin
            int nb, lo;
            v.fetch = ($urandom_range(0, 3) == 0);
            v.size  = v.fetch ? 2'd2 : 2'($urandom_range(0, 2));
            nb      = v.fetch ? 4 : (1 << v.size);
            lo      = $urandom_range(0, 3);
            if ($urandom_range(0, 2) != 0) lo = lo & ~(nb - 1);
            v.addr  = {$urandom, 2'b00} | 32'(lo);
            v.we    = v.fetch ? 1'b0 : 1'($urandom_range(0, 1));
            v.sgn   = v.fetch ? 1'b0 : 1'($urandom_range(0, 1));
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.waits = $urandom_range(0, 3);
            run_one($sformatf("rnd%0d", i), model(v));
        end

        bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_size = 2'b10; bif.d_signed = 1'b0;
        bif.d_addr = 32'h00006000; bif.waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_read_on", 32'(bif.read), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; bif.d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_read_off", 32'(bif.read), 32'd0);
        chk("rstmid_busy", 32'(bif.busy), 32'd0);
        reset = 1'b0; bif.waitrequest = 1'b0;
        m_last = DATA;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (bif.d_done || bif.if_done) dones++;
        end
        chk("rstmid_nodone", dones, 0);
        run_pair("pair3", 32'h00000300, 32'h00000400, 32'h76543210);

`ifdef MIPS_BUS_TIMEOUT_EN
        bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_size = 2'b10; bif.d_addr = 32'h00007000;
        lat = 0; bus_cyc = 0; to_dat = 32'hFFFFFFFF; to_err = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 1100; c++) begin
            @(negedge clk);
            if (bif.read) begin bus_cyc++; bif.waitrequest = 1'b1; end
            if (bif.d_done) begin lat = c; to_dat = bif.d_rdata; to_err = bif.d_err; break; end
        end
        @(posedge clk); #1;
        bif.d_req = 1'b0; bif.waitrequest = 1'b0;
        chk("timeout_latency", lat, 1025);
        chk("timeout_buscycles", bus_cyc, 1024);
        chk("timeout_err", 32'(to_err), 32'd1);
        chk("timeout_rdata", to_dat, 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
